// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - opcode/funct3 constants and FSM state type for branch resolution
package branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/branch_decode.sv
// rtl/branch_decode.sv - combinational control-transfer decode and taken decision
module branch_decode
  import branch_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] instruction_ex,
  input  logic              Br_eq,
  input  logic              Br_lt,
  output logic              is_ctrl,
  output logic              is_jalr,
  output logic              taken,
  output logic              Br_un
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode      = instruction_ex[6:0];
  assign funct3      = instruction_ex[14:12];
  assign unused_bits = ^{instruction_ex[DWIDTH-1:15], instruction_ex[11:7]};

  always_comb begin
    is_ctrl = 1'b0;
    is_jalr = 1'b0;
    taken   = 1'b0;
    Br_un   = 1'b0;
    case (opcode)
      OP_BRANCH: begin
        // Signedness of Br_lt is chosen here, so BLT/BLTU share one decision
        Br_un = (funct3 == F3_BLTU) || (funct3 == F3_BGEU);
        case (funct3)
          F3_BEQ:           begin is_ctrl = 1'b1; taken = Br_eq;  end
          F3_BNE:           begin is_ctrl = 1'b1; taken = !Br_eq; end
          F3_BLT, F3_BLTU:  begin is_ctrl = 1'b1; taken = Br_lt;  end
          F3_BGE, F3_BGEU:  begin is_ctrl = 1'b1; taken = !Br_lt; end
          default: ;
        endcase
      end
      OP_JAL: begin
        is_ctrl = 1'b1;
        taken   = 1'b1;
      end
      OP_JALR: begin
        is_ctrl = 1'b1;
        is_jalr = 1'b1;
        taken   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - redirect/flush sequencer with saturating branch counters
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 stall,
  input  logic [DWIDTH-1:0]    instruction_ex,
  input  logic [DWIDTH-1:0]    target_ex,
  input  logic                 Br_eq,
  input  logic                 Br_lt,
  output logic                 Br_un,
  output logic                 redirect_valid,
  output logic [DWIDTH-1:0]    redirect_pc,
  output logic                 flush_if,
  output logic                 flush_id,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FC_W-1:0] FC_INIT = FC_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  state_e                state_q, state_d;
  logic [FC_W-1:0]       cnt_q, cnt_d;
  logic [DWIDTH-1:0]     redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]  taken_cnt_q, taken_cnt_d;

  logic is_ctrl, is_jalr, taken, accept;

  branch_decode #(.DWIDTH(DWIDTH)) u_decode (
    .instruction_ex (instruction_ex),
    .Br_eq          (Br_eq),
    .Br_lt          (Br_lt),
    .is_ctrl        (is_ctrl),
    .is_jalr        (is_jalr),
    .taken          (taken),
    .Br_un          (Br_un)
  );

  // Wrong-path instructions arriving during REDIRECT/FLUSH are never accepted
  assign accept = ex_valid && !stall && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    branch_cnt_d  = branch_cnt_q;
    taken_cnt_d   = taken_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && taken) begin
          state_d       = REDIRECT;
          redirect_pc_d = target_ex;
          if (is_jalr) redirect_pc_d[0] = 1'b0;
        end
      end
      REDIRECT: begin
        if (FLUSH_CYCLES == 1) begin
          state_d = IDLE;
        end else begin
          state_d = FLUSH;
          cnt_d   = FC_INIT;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (accept && is_ctrl && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 1'b1;
    if (accept && taken && (taken_cnt_q != '1))    taken_cnt_d  = taken_cnt_q + 1'b1;
  end

  always_comb begin
    redirect_valid = (state_q == REDIRECT);
    flush_if       = (state_q != IDLE);
    flush_id       = (state_q != IDLE);
    busy           = (state_q != IDLE);
  end

  assign redirect_pc = redirect_pc_q;
  assign branch_cnt  = branch_cnt_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_valid4, stall, Br_eq, Br_lt;
  logic [31:0] instruction_ex, target_ex;

  logic        Br_un, redirect_valid, flush_if, flush_id, busy;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, taken_cnt;

  logic        Br_un4, redirect_valid4, flush_if4, flush_id4, busy4;
  logic [31:0] redirect_pc4;
  logic [3:0]  branch_cnt4, taken_cnt4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.DWIDTH(32), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall),
    .instruction_ex(instruction_ex), .target_ex(target_ex),
    .Br_eq(Br_eq), .Br_lt(Br_lt), .Br_un(Br_un),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id), .busy(busy),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_resolve_ctrl #(.DWIDTH(32), .FLUSH_CYCLES(1), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid4), .stall(stall),
    .instruction_ex(instruction_ex), .target_ex(target_ex),
    .Br_eq(Br_eq), .Br_lt(Br_lt), .Br_un(Br_un4),
    .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
    .flush_if(flush_if4), .flush_id(flush_id4), .busy(busy4),
    .branch_cnt(branch_cnt4), .taken_cnt(taken_cnt4)
  );

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {17'd0, f3, 5'd0, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_valid4 = 1'b0; stall = 1'b0;
    Br_eq = 1'b0; Br_lt = 1'b0; instruction_ex = 32'd0; target_ex = 32'd0;
    step(); step();
    rst = 1'b0;
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_flush_if", 32'(flush_if), 32'd0);
    check("rst_flush_id", 32'(flush_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_branch_cnt", 32'(branch_cnt), 32'd0);
    check("rst_taken_cnt", 32'(taken_cnt), 32'd0);

    // BEQ taken to 0x100
    instruction_ex = mk(3'b000, 7'b1100011); Br_eq = 1'b1; Br_lt = 1'b0;
    target_ex = 32'h100; ex_valid = 1'b1;
    #1 check("beq_br_un", 32'(Br_un), 32'd0);
    step(); ex_valid = 1'b0;
    check("beq_redirect_valid", 32'(redirect_valid), 32'd1);
    check("beq_redirect_pc", redirect_pc, 32'h100);
    check("beq_flush_if_c1", 32'(flush_if), 32'd1);
    check("beq_flush_id_c1", 32'(flush_id), 32'd1);
    check("beq_branch_cnt", 32'(branch_cnt), 32'd1);
    check("beq_taken_cnt", 32'(taken_cnt), 32'd1);
    step();
    check("beq_redirect_one_cycle", 32'(redirect_valid), 32'd0);
    check("beq_flush_if_c2", 32'(flush_if), 32'd1);
    check("beq_busy_c2", 32'(busy), 32'd1);
    step();
    check("beq_flush_done", 32'(flush_if), 32'd0);
    check("beq_idle", 32'(busy), 32'd0);

    // BLTU not taken
    instruction_ex = mk(3'b110, 7'b1100011); Br_eq = 1'b0; Br_lt = 1'b0;
    target_ex = 32'h200; ex_valid = 1'b1;
    #1 check("bltu_br_un", 32'(Br_un), 32'd1);
    step(); ex_valid = 1'b0;
    check("bltu_no_redirect", 32'(redirect_valid), 32'd0);
    check("bltu_not_busy", 32'(busy), 32'd0);
    check("bltu_branch_cnt", 32'(branch_cnt), 32'd2);
    check("bltu_taken_cnt", 32'(taken_cnt), 32'd1);

    // BGE with Br_lt=0 is taken
    instruction_ex = mk(3'b101, 7'b1100011); target_ex = 32'h300; ex_valid = 1'b1;
    #1 check("bge_br_un", 32'(Br_un), 32'd0);
    step(); ex_valid = 1'b0;
    check("bge_redirect_valid", 32'(redirect_valid), 32'd1);
    check("bge_redirect_pc", redirect_pc, 32'h300);
    check("bge_counts", {branch_cnt, taken_cnt}, {16'd3, 16'd2});
    step(); step();

    // JALR clears bit 0 of the target
    instruction_ex = mk(3'b000, 7'b1100111); target_ex = 32'h203; ex_valid = 1'b1;
    step(); ex_valid = 1'b0;
    check("jalr_redirect_valid", 32'(redirect_valid), 32'd1);
    check("jalr_redirect_pc", redirect_pc, 32'h202);
    check("jalr_counts", {branch_cnt, taken_cnt}, {16'd4, 16'd3});
    step(); step();

    // JAL keeps the target as-is
    instruction_ex = mk(3'b000, 7'b1101111); target_ex = 32'h401; ex_valid = 1'b1;
    step(); ex_valid = 1'b0;
    check("jal_redirect_pc", redirect_pc, 32'h401);
    check("jal_counts", {branch_cnt, taken_cnt}, {16'd5, 16'd4});
    step(); step();

    // Illegal branch funct3 and a non-control opcode: no effect
    instruction_ex = mk(3'b010, 7'b1100011); Br_eq = 1'b1; target_ex = 32'h900; ex_valid = 1'b1;
    step();
    check("illegal_no_redirect", 32'(redirect_valid), 32'd0);
    check("illegal_counts", {branch_cnt, taken_cnt}, {16'd5, 16'd4});
    instruction_ex = mk(3'b110, 7'b0110011);
    #1 check("alu_br_un", 32'(Br_un), 32'd0);
    step(); ex_valid = 1'b0;
    check("alu_no_busy", 32'(busy), 32'd0);
    check("alu_counts", {branch_cnt, taken_cnt}, {16'd5, 16'd4});

    // Taken BEQ then a taken BNE in its flush shadow
    instruction_ex = mk(3'b000, 7'b1100011); Br_eq = 1'b1; target_ex = 32'h500; ex_valid = 1'b1;
    step();
    instruction_ex = mk(3'b001, 7'b1100011); Br_eq = 1'b0; target_ex = 32'h600;
    check("shadow_first_pc", redirect_pc, 32'h500);
    step();
    check("shadow_no_second_redirect", 32'(redirect_valid), 32'd0);
    step(); ex_valid = 1'b0;
    check("shadow_idle", 32'(busy), 32'd0);
    step();
    check("shadow_no_redirect_after", 32'(redirect_valid), 32'd0);
    check("shadow_pc_kept", redirect_pc, 32'h500);
    check("shadow_counts", {branch_cnt, taken_cnt}, {16'd6, 16'd5});

    // Stalled taken BEQ waits for the stall to drop
    instruction_ex = mk(3'b000, 7'b1100011); Br_eq = 1'b1; target_ex = 32'h700;
    ex_valid = 1'b1; stall = 1'b1;
    step(); step();
    check("stall_no_redirect", 32'(redirect_valid), 32'd0);
    check("stall_no_count", 32'(branch_cnt), 32'd6);
    stall = 1'b0;
    step(); ex_valid = 1'b0;
    check("stall_release_redirect", 32'(redirect_valid), 32'd1);
    check("stall_release_pc", redirect_pc, 32'h700);
    check("stall_release_counts", {branch_cnt, taken_cnt}, {16'd7, 16'd6});

    // Reset while in FLUSH
    step();
    check("pre_rst_flush", 32'(flush_if), 32'd1);
    rst = 1'b1;
    step(); rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_flush", {31'd0, flush_if | flush_id}, 32'd0);
    check("midrst_redirect_pc", redirect_pc, 32'd0);
    check("midrst_counts", {branch_cnt, taken_cnt}, 32'd0);

    // FLUSH_CYCLES=1, 4-bit counters: 20 taken branches saturate at 15
    instruction_ex = mk(3'b000, 7'b1100011); Br_eq = 1'b1; target_ex = 32'h800; ex_valid4 = 1'b1;
    step();
    check("fc1_redirect_valid", 32'(redirect_valid4), 32'd1);
    check("fc1_flush_id", 32'(flush_id4), 32'd1);
    step();
    check("fc1_idle_after_one", 32'(busy4), 32'd0);
    repeat (38) step();
    ex_valid4 = 1'b0;
    step();
    check("sat_branch_cnt", 32'(branch_cnt4), 32'd15);
    check("sat_taken_cnt", 32'(taken_cnt4), 32'd15);
    check("sat_other_dut_idle", 32'(branch_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
